// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with whole-matrix debounce.
// Emits one KEY_Value/Value_en event per accepted single-key press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] KEY_Value,
  output logic       Value_en,
  output logic       key_down
);

  localparam int             DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]     DEB_MAX  = 4'(DEBOUNCE_SCANS);

  typedef enum logic {IDLE, HELD} state_t;

  state_t           state;
  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [15:0]      snap, prev_snap, deb;
  logic [15:0]      cur_snap, deb_next;
  logic [3:0]       stable_cnt, cnt_next;
  logic             sample_now, scan_end, deb_load, one_hot;
  logic [3:0]       hit_idx;

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:  key_code = 4'd1;
      4'd1:  key_code = 4'd2;
      4'd2:  key_code = 4'd3;
      4'd3:  key_code = 4'd10;
      4'd4:  key_code = 4'd4;
      4'd5:  key_code = 4'd5;
      4'd6:  key_code = 4'd6;
      4'd7:  key_code = 4'd11;
      4'd8:  key_code = 4'd7;
      4'd9:  key_code = 4'd8;
      4'd10: key_code = 4'd9;
      4'd11: key_code = 4'd12;
      4'd12: key_code = 4'd14;
      4'd13: key_code = 4'd0;
      4'd14: key_code = 4'd15;
      default: key_code = 4'd13;
    endcase
  endfunction

  // Rows idle high, so the synchronizer resets to the "no key" level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      col_idx <= 2'd0;
    end else if (div == DIV_LAST) begin
      div     <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign col_out    = ~(4'b0001 << col_idx);
  assign sample_now = (div == DIV_LAST);
  assign scan_end   = sample_now && (col_idx == 2'd3);

  // Snapshot as it will look after this cycle, so the scan end sees column 3 too.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_snap = snap;
    if (sample_now)
      for (int r = 0; r < 4; r++)
        cur_snap[{2'(r), col_idx}] = ~row_sync[r];

    if (cur_snap != prev_snap) cnt_next = 4'd0;
    else if (stable_cnt == DEB_MAX) cnt_next = DEB_MAX;
    else cnt_next = stable_cnt + 4'd1;

    deb_load = scan_end && (cnt_next == DEB_MAX);
    deb_next = deb_load ? cur_snap : deb;
    one_hot  = (deb_next != 16'd0) && ((deb_next & (deb_next - 16'd1)) == 16'd0);

    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++)
      if (deb_next[i]) hit_idx = 4'(i);
  end

  // NOTE: snapshot registers are cleared on reset so a partial scan can never debounce into an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap       <= '0;
      prev_snap  <= '0;
      stable_cnt <= 4'd0;
      deb        <= '0;
    end else begin
      snap <= cur_snap;
      if (scan_end) begin
        prev_snap  <= cur_snap;
        stable_cnt <= cnt_next;
      end
      deb <= deb_next;
    end
  end

  // Events only on the IDLE->HELD transition; changes while held are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      KEY_Value <= 4'd0;
      Value_en  <= 1'b0;
    end else begin
      Value_en <= 1'b0;
      case (state)
        IDLE: if (deb_next != 16'd0) begin
          state <= HELD;
          if (one_hot) begin
            KEY_Value <= key_code(hit_idx);
            Value_en  <= 1'b1;
          end
        end
        HELD: if (deb_next == 16'd0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign key_down = (state == HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus queues expected events,
// a negedge monitor pops and compares them whenever Value_en fires.
module tb_keypad_scanner;

  localparam int SD   = 8;
  localparam int DS   = 3;
  localparam int SCAN = 4 * SD;
  localparam int LAT  = (DS + 1) * SCAN;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in, col_out, KEY_Value;
  logic        Value_en, key_down;
  logic [15:0] keys;
  int          cyc;
  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .KEY_Value(KEY_Value), .Value_en(Value_en), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its driven column.
  always_comb begin
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_key(input logic [3:0] code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && Value_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(KEY_Value), 32'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("key_value", 32'(KEY_Value), 32'(e.code));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    rst  = 1'b1;
    keys = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_col_out", 32'(col_out), 32'b1110);
    check("rst_key_value", 32'(KEY_Value), 32'd0);
    check("rst_value_en", 32'(Value_en), 32'd0);
    check("rst_key_down", 32'(key_down), 32'd0);
    rst = 1'b0;

    // Column walk
    step(7);  check("col_c7", 32'(col_out), 32'b1110);
    step(1);  check("col_c8", 32'(col_out), 32'b1101);
    step(8);  check("col_c16", 32'(col_out), 32'b1011);
    step(8);  check("col_c24", 32'(col_out), 32'b0111);
    step(8);  check("col_c32", 32'(col_out), 32'b1110);
    step(4 * SCAN);

    // Single press "7"
    keys[8] = 1'b1;
    expect_key(4'd7, cyc + LAT);
    step(10 * SCAN);
    check("seven_key_down", 32'(key_down), 32'd1);
    check("seven_held_value", 32'(KEY_Value), 32'd7);
    keys = 16'd0;
    step(LAT - 1);
    check("seven_release_hold", 32'(key_down), 32'd1);
    step(1);
    check("seven_release_done", 32'(key_down), 32'd0);
    step(2 * SCAN);

    // Bouncing "A", then steady
    for (int i = 0; i < 6; i++) begin
      keys[3] = (i % 2 == 0);
      step(SCAN);
    end
    keys[3] = 1'b1;
    expect_key(4'd10, cyc + LAT);
    step(6 * SCAN);
    keys = 16'd0;
    step(6 * SCAN);

    // "1" and "2" together: held but no event
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    step(5 * SCAN);
    check("two_keys_down", 32'(key_down), 32'd1);
    keys = 16'd0;
    step(6 * SCAN);
    check("two_keys_released", 32'(key_down), 32'd0);
    keys[13] = 1'b1;
    expect_key(4'd0, cyc + LAT);
    step(6 * SCAN);
    keys = 16'd0;
    step(6 * SCAN);

    // Rollover: "5" then "9" on top
    keys[5] = 1'b1;
    expect_key(4'd5, cyc + LAT);
    step(6 * SCAN);
    keys[10] = 1'b1;
    step(6 * SCAN);
    check("rollover_down", 32'(key_down), 32'd1);
    check("rollover_value", 32'(KEY_Value), 32'd5);
    keys = 16'd0;
    step(6 * SCAN);
    keys[15] = 1'b1;
    expect_key(4'd13, cyc + LAT);
    step(6 * SCAN);
    keys = 16'd0;
    step(6 * SCAN);

    // Reset two scans into a "3" press
    keys[2] = 1'b1;
    step(2 * SCAN);
    rst = 1'b1;
    #1;
    check("midrst_col_out", 32'(col_out), 32'b1110);
    check("midrst_key_value", 32'(KEY_Value), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_key(4'd3, LAT);
    step(6 * SCAN);
    check("midrst_after_value", 32'(KEY_Value), 32'd3);
    keys = 16'd0;
    step(6 * SCAN);

    check("pending_events", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
